// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and constants.
// Used by the fetch stage and its interface.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage port bundle: icache, hazard and
// fetch/decode latch signals.
interface fetch_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  logic  update;
  logic  flush;
  word_t instruction_in;
  word_t normal_pc_in;
  word_t next_pc_in;
  word_t pc_out;

  modport fs (
    input  ihit,
    input  imemload,
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  halt,
    output imemREN,
    output imemaddr,
    output update,
    output flush,
    output instruction_in,
    output normal_pc_in,
    output next_pc_in,
    output pc_out
  );

  modport cache (
    input  imemREN,
    input  imemaddr,
    output ihit,
    output imemload
  );

endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, icache reads, one-entry
// stall buffer, redirect and halt handling.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC0 = 32'h00000000
) (
  input  logic CLK,
  input  logic RST,
  fetch_if.fs  fif
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  word_t pc;
  word_t pc_nxt;
  word_t pc_inc;
  word_t buf_instr;
  word_t buf_npc;
  word_t buf_instr_nxt;
  word_t buf_npc_nxt;

  logic  ren;
  logic  upd;
  logic  fl;
  word_t instr;
  word_t npc;
  word_t nxt;

  assign pc_inc = pc + PC_STEP;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // PC and stall buffer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= PC0;
      buf_instr <= '0;
      buf_npc   <= '0;
    end else begin
      pc        <= pc_nxt;
      buf_instr <= buf_instr_nxt;
      buf_npc   <= buf_npc_nxt;
    end
  end

  // Next state: halt beats redirect beats fetch/stall
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    buf_instr_nxt = buf_instr;
    buf_npc_nxt   = buf_npc;
    if (state != HALTED) begin
      if (fif.halt) begin
        state_nxt = HALTED;
      end else if (fif.redirect) begin
        state_nxt     = RUN;
        pc_nxt        = fif.redirect_pc;
        buf_instr_nxt = '0;
        buf_npc_nxt   = '0;
      end else if (state == HOLD) begin
        if (!fif.stall) state_nxt = RUN;
      end else if (fif.ihit) begin
        pc_nxt = pc_inc;
        if (fif.stall) begin
          state_nxt     = HOLD;
          buf_instr_nxt = fif.imemload;
          buf_npc_nxt   = pc_inc;
        end
      end
    end
  end

  // Outputs to icache and fetch/decode latch
  always_comb begin
    ren   = 1'b0;
    upd   = 1'b0;
    fl    = 1'b0;
    instr = '0;
    npc   = '0;
    nxt   = pc;
    if (RST) begin
      nxt = PC0;
    end else if (state == HALTED) begin
      nxt = pc;
    end else if (fif.halt) begin
      fl = 1'b1;
    end else if (fif.redirect) begin
      fl  = 1'b1;
      ren = (state != HOLD);
      nxt = fif.redirect_pc;
    end else if (state == HOLD) begin
      if (!fif.stall) begin
        upd   = 1'b1;
        instr = buf_instr;
        npc   = buf_npc;
      end
    end else begin
      ren = 1'b1;
      if (fif.ihit) begin
        nxt = pc_inc;
        if (!fif.stall) begin
          upd   = 1'b1;
          instr = fif.imemload;
          npc   = pc_inc;
        end
      end
    end
  end

  assign fif.imemREN        = ren;
  assign fif.imemaddr       = pc;
  assign fif.update         = upd;
  assign fif.flush          = fl;
  assign fif.instruction_in = instr;
  assign fif.normal_pc_in   = npc;
  assign fif.next_pc_in     = nxt;
  assign fif.pc_out         = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table,
// random run against a queue model, halt sequence.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_if f0();
  fetch_if f1();

  fetch_stage #(.PC0(32'h00000000)) u0 (
    .CLK(clk), .RST(rst0), .fif(f0));
  fetch_stage #(.PC0(32'h00000200)) u1 (
    .CLK(clk), .RST(rst1), .fif(f1));

  typedef struct {
    logic  rst;
    logic  ihit;
    word_t load;
    logic  stall;
    logic  redir;
    word_t rpc;
    logic  halt;
    logic  ren;
    word_t addr;
    logic  upd;
    logic  fl;
    word_t instr;
    word_t npc;
    word_t nxt;
  } vec_t;

  typedef struct {
    word_t i;
    word_t n;
  } ent_t;

  vec_t vq[$];

  task automatic chk(string nm, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(logic rs, logic ih, word_t ld,
      logic st, logic rd, word_t rp, logic hl,
      logic ren, word_t addr, logic upd, logic fl,
      word_t instr, word_t npc, word_t nxt);
    vec_t v;
    v = '{rs, ih, ld, st, rd, rp, hl,
          ren, addr, upd, fl, instr, npc, nxt};
    vq.push_back(v);
  endtask

  task automatic drive0(logic rs, logic ih, word_t ld,
      logic st, logic rd, word_t rp, logic hl);
    rst0 = rs;
    f0.ihit = ih;
    f0.imemload = ld;
    f0.stall = st;
    f0.redirect = rd;
    f0.redirect_pc = rp;
    f0.halt = hl;
  endtask

  task automatic drive1(logic rs, logic ih, word_t ld,
      logic st, logic rd, word_t rp, logic hl);
    rst1 = rs;
    f1.ihit = ih;
    f1.imemload = ld;
    f1.stall = st;
    f1.redirect = rd;
    f1.redirect_pc = rp;
    f1.halt = hl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model state
  word_t m_pc;
  ent_t  m_q[$];
  logic  m_halted;

  initial begin
    ent_t  e;
    logic  rs, ih, st, rd, hl;
    word_t ld, rp;
    logic  e_ren, e_upd, e_fl;
    word_t e_instr, e_npc, e_nxt;

    drive0(1, 0, 0, 0, 0, 0, 0);
    drive1(1, 0, 0, 0, 0, 0, 0);

    // directed table on core-0 instance
    add(1,1,32'h8C010004,0,0,0,0, 0,32'h0,0,0,0,0,32'h0);
    add(0,1,32'h8C010004,0,0,0,0,
        1,32'h0,1,0,32'h8C010004,32'h4,32'h4);
    add(0,1,32'h8C010004,0,0,0,0,
        1,32'h4,1,0,32'h8C010004,32'h8,32'h8);
    add(0,1,32'h8C010004,0,0,0,0,
        1,32'h8,1,0,32'h8C010004,32'hC,32'hC);
    add(0,1,32'h8C010004,0,0,0,0,
        1,32'hC,1,0,32'h8C010004,32'h10,32'h10);
    add(0,1,32'hAAAA0010,1,0,0,0, 1,32'h10,0,0,0,0,32'h14);
    add(0,1,32'hBBBB0014,1,0,0,0, 0,32'h14,0,0,0,0,32'h14);
    add(0,1,32'hBBBB0014,1,0,0,0, 0,32'h14,0,0,0,0,32'h14);
    add(0,1,32'hBBBB0014,1,0,0,0, 0,32'h14,0,0,0,0,32'h14);
    add(0,1,32'hBBBB0014,0,0,0,0,
        0,32'h14,1,0,32'hAAAA0010,32'h14,32'h14);
    add(0,1,32'h11110014,0,0,0,0,
        1,32'h14,1,0,32'h11110014,32'h18,32'h18);
    add(0,1,32'h22220018,0,0,0,0,
        1,32'h18,1,0,32'h22220018,32'h1C,32'h1C);
    add(0,1,32'h2222001C,0,0,0,0,
        1,32'h1C,1,0,32'h2222001C,32'h20,32'h20);
    add(0,1,32'hDEAD0020,0,1,32'h100,0,
        1,32'h20,0,1,0,0,32'h100);
    add(0,1,32'h33330100,0,0,0,0,
        1,32'h100,1,0,32'h33330100,32'h104,32'h104);
    add(0,1,32'h44440104,1,0,0,0, 1,32'h104,0,0,0,0,32'h108);
    add(0,1,32'h99990108,1,1,32'h200,0,
        0,32'h108,0,1,0,0,32'h200);
    add(0,0,32'h0,0,0,0,0, 1,32'h200,0,0,0,0,32'h200);
    add(0,0,32'h0,1,0,0,0, 1,32'h200,0,0,0,0,32'h200);
    add(0,1,32'h55550200,0,0,0,0,
        1,32'h200,1,0,32'h55550200,32'h204,32'h204);
    add(0,0,32'h0,0,1,32'hFFFFFFFC,0,
        1,32'h204,0,1,0,0,32'hFFFFFFFC);
    add(0,1,32'h66660000,0,0,0,0,
        1,32'hFFFFFFFC,1,0,32'h66660000,32'h0,32'h0);
    add(0,0,32'h0,0,0,0,0, 1,32'h0,0,0,0,0,32'h0);

    foreach (vq[k]) begin
      drive0(vq[k].rst, vq[k].ihit, vq[k].load,
             vq[k].stall, vq[k].redir, vq[k].rpc, vq[k].halt);
      #3;
      chk($sformatf("v%0d ren", k), {31'b0, f0.imemREN},
          {31'b0, vq[k].ren});
      chk($sformatf("v%0d addr", k), f0.imemaddr, vq[k].addr);
      chk($sformatf("v%0d upd", k), {31'b0, f0.update},
          {31'b0, vq[k].upd});
      chk($sformatf("v%0d flush", k), {31'b0, f0.flush},
          {31'b0, vq[k].fl});
      chk($sformatf("v%0d next", k), f0.next_pc_in, vq[k].nxt);
      if (vq[k].upd) begin
        chk($sformatf("v%0d instr", k), f0.instruction_in,
            vq[k].instr);
        chk($sformatf("v%0d npc", k), f0.normal_pc_in,
            vq[k].npc);
      end
      tick();
    end

    // random run against a queue-based model
    m_pc = 32'h0;
    m_halted = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rs = (c == 0) ||
           (m_halted ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 80) == 0));
      ih = ($urandom_range(0, 9) < 6);
      st = ($urandom_range(0, 9) < 4);
      rd = ($urandom_range(0, 9) == 0);
      hl = ($urandom_range(0, 60) == 0);
      ld = $urandom;
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8
                                       : ($urandom & ~32'h3);
      drive0(rs, ih, ld, st, rd, rp, hl);

      e_ren = 0; e_upd = 0; e_fl = 0;
      e_instr = 0; e_npc = 0; e_nxt = m_pc;
      if (rs) begin
        m_pc = 32'h0;
        m_q.delete();
        m_halted = 0;
        e_nxt = 32'h0;
      end else if (m_halted) begin
        e_nxt = m_pc;
      end else if (hl) begin
        e_fl = 1;
        m_halted = 1;
      end else if (rd) begin
        e_fl = 1;
        e_ren = (m_q.size() == 0);
        e_nxt = rp;
      end else if (m_q.size() != 0) begin
        if (!st) begin
          e_upd = 1;
          e_instr = m_q[0].i;
          e_npc = m_q[0].n;
        end
      end else begin
        e_ren = 1;
        if (ih) begin
          e_nxt = m_pc + 32'd4;
          if (!st) begin
            e_upd = 1;
            e_instr = ld;
            e_npc = m_pc + 32'd4;
          end
        end
      end

      #3;
      chk($sformatf("r%0d ren", c), {31'b0, f0.imemREN},
          {31'b0, e_ren});
      chk($sformatf("r%0d pc", c), f0.pc_out, m_pc);
      chk($sformatf("r%0d addr", c), f0.imemaddr, m_pc);
      chk($sformatf("r%0d upd", c), {31'b0, f0.update},
          {31'b0, e_upd});
      chk($sformatf("r%0d flush", c), {31'b0, f0.flush},
          {31'b0, e_fl});
      chk($sformatf("r%0d next", c), f0.next_pc_in, e_nxt);
      if (e_upd) begin
        chk($sformatf("r%0d instr", c), f0.instruction_in,
            e_instr);
        chk($sformatf("r%0d npc", c), f0.normal_pc_in, e_npc);
      end

      if (!rs && !m_halted && !hl) begin
        if (rd) begin
          m_pc = rp;
          m_q.delete();
        end else if (m_q.size() != 0) begin
          if (!st) void'(m_q.pop_front());
        end else if (ih) begin
          if (st) begin
            e.i = ld;
            e.n = m_pc + 32'd4;
            m_q.push_back(e);
          end
          m_pc = m_pc + 32'd4;
        end
      end
      tick();
    end
    drive0(1, 0, 0, 0, 0, 0, 0);

    // halt with concurrent redirect on core-1 instance
    drive1(1, 1, 32'h12345678, 0, 0, 0, 0);
    #3;
    chk("h rst pc", f1.pc_out, 32'h200);
    chk("h rst next", f1.next_pc_in, 32'h200);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive1(0, 1, 32'h12345678, 0, 0, 0, 0);
      #3;
      chk($sformatf("h run%0d addr", i), f1.imemaddr,
          32'h200 + 32'(i * 4));
      chk($sformatf("h run%0d upd", i), {31'b0, f1.update}, 32'd1);
      tick();
    end
    drive1(0, 1, 32'h12345678, 0, 1, 32'h40, 1);
    #3;
    chk("h flush", {31'b0, f1.flush}, 32'd1);
    chk("h upd", {31'b0, f1.update}, 32'd0);
    chk("h ren", {31'b0, f1.imemREN}, 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive1(0, 1, 32'h12345678, 0, (i % 3) == 0, 32'h80, 0);
      #3;
      chk($sformatf("hh%0d ren", i), {31'b0, f1.imemREN}, 32'd0);
      chk($sformatf("hh%0d upd", i), {31'b0, f1.update}, 32'd0);
      chk($sformatf("hh%0d flush", i), {31'b0, f1.flush}, 32'd0);
      chk($sformatf("hh%0d pc", i), f1.pc_out, 32'h208);
      tick();
    end
    drive1(1, 1, 32'h12345678, 0, 0, 0, 0);
    #3;
    chk("h reset pc", f1.pc_out, 32'h200);
    chk("h reset ren", {31'b0, f1.imemREN}, 32'd0);
    tick();
    drive1(0, 1, 32'h12345678, 0, 0, 0, 0);
    #3;
    chk("h restart addr", f1.imemaddr, 32'h200);
    chk("h restart upd", {31'b0, f1.update}, 32'd1);
    chk("h restart npc", f1.normal_pc_in, 32'h204);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
